// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter and its lane aligner.
package mem_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} mem_size_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} arb_state_t;

  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  localparam logic [7:0] BE_MASK_B = 8'h01;
  localparam logic [7:0] BE_MASK_H = 8'h03;
  localparam logic [7:0] BE_MASK_W = 8'h0F;
  localparam logic [7:0] BE_MASK_D = 8'hFF;

  function automatic logic [7:0] be_mask(input mem_size_t sz);
    case (sz)
      SZ_B:    return BE_MASK_B;
      SZ_H:    return BE_MASK_H;
      SZ_W:    return BE_MASK_W;
      default: return BE_MASK_D;
    endcase
  endfunction

  function automatic logic [63:0] data_mask(input mem_size_t sz);
    logic [7:0]  be;
    logic [63:0] m;
    be = be_mask(sz);
    m  = '0;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter; master = arbiter, slave = environment.
interface mem_port_arbiter_if #(parameter int ADDR_W = 48);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [63:0]       ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [63:0]       ls_rdata;
  logic              ls_misaligned;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_be;
  logic [63:0]       mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [63:0]       mem_rdata;

  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_misaligned,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, ls_misaligned,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// Combinational lane logic: alignment check, byte enables and write shift on the request side,
// read extraction and size masking on the response side.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_size_t   i_size,
  input  logic [2:0]  i_addr_lo,
  input  logic [63:0] i_wdata,
  output logic        o_misaligned,
  output logic [7:0]  o_be,
  output logic [63:0] o_wdata,
  input  mem_size_t   i_rsp_size,
  input  logic [2:0]  i_rsp_addr_lo,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_rdata
);

  always_comb begin
    case (i_size)
      SZ_B:    o_misaligned = 1'b0;
      SZ_H:    o_misaligned = i_addr_lo[0];
      SZ_W:    o_misaligned = |i_addr_lo[1:0];
      default: o_misaligned = |i_addr_lo;
    endcase
  end

  assign o_be    = be_mask(i_size) << i_addr_lo;
  assign o_wdata = i_wdata << {i_addr_lo, 3'b000};
  assign o_rdata = (i_rdata >> {i_rsp_addr_lo, 3'b000}) & data_mask(i_rsp_size);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between fetch and load/store, one transaction in flight.
// Define MEM_ARB_STARVE_EN to let fetch win after STARVE_MAX consecutive load/store grants.
//
// state    | meaning
// ST_IDLE  | arbitrate, grant and capture payload
// ST_ISSUE | mem_req held until mem_ready
// ST_WAIT  | wait for mem_rvalid, capture read data
// ST_RESP  | one-cycle rvalid to the owner
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 48,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  mem_port_arbiter_if.master bus
);

  arb_state_t        r_state, w_state_nxt;
  owner_t            r_owner;
  logic              r_we, r_mis;
  mem_size_t         r_size;
  logic [2:0]        r_lo;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_be;
  logic [63:0]       r_wdata, r_rdata;

  logic        w_pick_if, w_starve_hit, w_ls_mis;
  logic [7:0]  w_ls_be;
  logic [63:0] w_ls_wdata, w_rdata_ex;

  mem_lane_align u_align (
    .i_size       (mem_size_t'(bus.ls_size)),
    .i_addr_lo    (bus.ls_addr[2:0]),
    .i_wdata      (bus.ls_wdata),
    .o_misaligned (w_ls_mis),
    .o_be         (w_ls_be),
    .o_wdata      (w_ls_wdata),
    .i_rsp_size   (r_size),
    .i_rsp_addr_lo(r_lo),
    .i_rdata      (bus.mem_rdata),
    .o_rdata      (w_rdata_ex)
  );

`ifdef MEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] r_starve;

  assign w_starve_hit = (r_starve == CNT_W'(STARVE_MAX));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                     r_starve <= '0;
    else if (bus.if_gnt)              r_starve <= '0;
    else if (bus.ls_gnt && bus.if_req) r_starve <= r_starve + 1'b1;
  end
`else
  assign w_starve_hit = 1'b0;
`endif

  assign w_pick_if = bus.if_req && (!bus.ls_req || w_starve_hit);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.if_gnt    = 1'b0;
    bus.ls_gnt    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.ls_rvalid = 1'b0;
    bus.mem_req   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_if) begin
          bus.if_gnt  = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else if (bus.ls_req) begin
          bus.ls_gnt  = 1'b1;
          w_state_nxt = w_ls_mis ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.if_rvalid = (r_owner == OWN_IF);
        bus.ls_rvalid = (r_owner == OWN_LS);
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // r_rdata is cleared at every grant so stores and misaligned accesses answer with zero.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_size  <= SZ_B;
      r_lo    <= '0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (bus.if_gnt) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_size  <= SZ_D;
      r_lo    <= {bus.if_addr[2], 2'b00};
      r_addr  <= {bus.if_addr[ADDR_W-1:3], 3'b000};
      r_be    <= BE_MASK_D;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (bus.ls_gnt) begin
      r_owner <= OWN_LS;
      r_we    <= bus.ls_we;
      r_mis   <= w_ls_mis;
      r_size  <= mem_size_t'(bus.ls_size);
      r_lo    <= bus.ls_addr[2:0];
      r_addr  <= {bus.ls_addr[ADDR_W-1:3], 3'b000};
      r_be    <= w_ls_be;
      r_wdata <= w_ls_wdata;
      r_rdata <= '0;
    end else if (r_state == ST_WAIT && bus.mem_rvalid && !r_we) begin
      if (r_owner == OWN_IF)
        r_rdata <= {32'h0, r_lo[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0]};
      else
        r_rdata <= w_rdata_ex;
    end
  end

  assign bus.mem_we        = bus.mem_req & r_we;
  assign bus.mem_addr      = bus.mem_req ? r_addr : '0;
  assign bus.mem_be        = bus.mem_req ? r_be : '0;
  assign bus.mem_wdata     = bus.mem_req ? r_wdata : '0;
  assign bus.ls_rdata      = bus.ls_rvalid ? r_rdata : '0;
  assign bus.ls_misaligned = bus.ls_rvalid & r_mis;
  assign bus.if_rdata      = bus.if_rvalid ? r_rdata[31:0] : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and sequencer that shares one 64-bit memory interface between the instruction-fetch stage and the load/store (memory) stage of the RV64IMFD pipeline. It selects one requester at a time, generates byte enables and lane-aligned write data from access size and address, returns lane-extracted read data to the owner, and reports misaligned load/store accesses as traps without touching memory. It sits between the pipeline stages and the external memory model/controller.

## Interface
- `ADDR_W`, 48, byte address width
- `STARVE_MAX`, 4, consecutive load/store grants allowed while fetch waits (only with starvation control)
- `clk` in 1, clock
- `n_reset` in 1, asynchronous active-low reset
- `if_req` in 1, fetch request; held with `if_addr` until `if_gnt`
- `if_addr` in ADDR_W, fetch address; bits [1:0] ignored (treated as 0)
- `if_gnt` out 1, one-cycle grant pulse
- `if_rvalid` out 1, one-cycle response pulse
- `if_rdata` out 32, instruction word: `mem_rdata` half selected by `if_addr[2]`
- `ls_req` in 1, load/store request; held with its payload until `ls_gnt`
- `ls_we` in 1, 1 = store
- `ls_size` in 2, 0 byte, 1 half, 2 word, 3 double
- `ls_addr` in ADDR_W, byte address
- `ls_wdata` in 64, store data, right-justified
- `ls_gnt` out 1, one-cycle grant pulse
- `ls_rvalid` out 1, one-cycle response pulse (loads and stores)
- `ls_rdata` out 64, load data right-justified, zero-extended beyond size; 0 for stores
- `ls_misaligned` out 1, valid with `ls_rvalid`; access was not issued
- `mem_req` out 1, memory request, held until `mem_ready`
- `mem_we` out 1, write enable
- `mem_addr` out ADDR_W, address with bits [2:0] forced to 0
- `mem_be` out 8, byte enables
- `mem_wdata` out 64, lane-aligned write data
- `mem_ready` in 1, request accepted this cycle
- `mem_rvalid` in 1, response (read data or write ack), exactly one per accepted request
- `mem_rdata` in 64, read data

## Operation
- FSM: IDLE, ISSUE, WAIT, RESP. One transaction outstanding.
- IDLE: if any request, `*_gnt` asserted combinationally for the winner; payload captured at the edge; next state ISSUE (or RESP if misaligned load/store).
- Priority: load/store over fetch; fetch wins only per starvation rule (Configuration).
- Misaligned: `ls_addr` not a multiple of 2^`ls_size`. Goes straight to RESP, `ls_misaligned`=1, `ls_rdata`=0, no `mem_req`.
- ISSUE: `mem_req`=1 with registered address/be/data; on `mem_ready` go to WAIT.
- WAIT: on `mem_rvalid` capture `mem_rdata` and go to RESP.
- RESP: owner's `*_rvalid` pulses one cycle from registered data; back to IDLE (no grant in RESP).
- Byte enables: size mask (0x01, 0x03, 0x0F, 0xFF) shifted left by `ls_addr[2:0]`; fetch uses 0xFF, `mem_we`=0.
- Write data: `ls_wdata` shifted left by 8*`ls_addr[2:0]`, bits beyond 64 dropped.
- Read data: `mem_rdata` shifted right by 8*`ls_addr[2:0]`, masked to size. Sign extension is the memory stage's job.
- `mem_rvalid` outside WAIT ignored.

## Timing
- Reset: state IDLE, every output 0, starvation counter 0, captured registers 0.
- Best-case aligned access: grant cycle N, `mem_req` N+1 (with `mem_ready` N+1), `mem_rvalid` earliest N+2, requester `*_rvalid` N+3.
- Misaligned: grant N, `ls_rvalid`/`ls_misaligned` N+1.
- Back-to-back: next grant earliest the cycle after RESP.
- Simultaneous `if_req` and `ls_req` in IDLE: exactly one grant.
- Reset mid-transaction: immediate return to IDLE; in-flight response discarded; requester must re-request.

## Configuration
- `MEM_ARB_STARVE_EN` defined: counter increments on each load/store grant while `if_req` is high, clears on fetch grant; when it equals `STARVE_MAX`, fetch wins the next simultaneous arbitration.
- Not defined: strict load/store priority, no counter; `STARVE_MAX` unused.

## Structure
- Shared package `mem_pkg`: `mem_size_t` enum (SZ_B, SZ_H, SZ_W, SZ_D), arbiter state enum, owner enum (OWN_IF, OWN_LS), byte-enable mask constants.
- Sub-module `mem_lane_align` (combinational): misalignment check, `mem_be`, write shift, read extract/mask.

## Test plan
- Aligned double load addr 0x1000, `mem_rdata`=0x1122334455667788 -> `mem_be`=0xFF, `ls_rvalid` at N+3, `ls_rdata`=0x1122334455667788.
- Byte store addr 0x1003, wdata 0xAB -> `mem_be`=0x08, `mem_wdata`=0x00000000AB000000, `mem_addr`=0x1000, ack -> `ls_rvalid`, `ls_rdata`=0.
- Half load addr 0x2001 -> no `mem_req`, `ls_rvalid`+`ls_misaligned` at N+1.
- Both requesting, fetch addr 0x3004, `mem_rdata`=0xDEADBEEF_00000013 -> load/store granted first; fetch then returns `if_rdata`=0xDEADBEEF.
- With `MEM_ARB_STARVE_EN`, `STARVE_MAX`=4, both held continuously -> grants LS,LS,LS,LS,IF repeating; without macro -> LS only.
- Assert `n_reset` low during WAIT, then `mem_rvalid` -> all outputs 0, no `*_rvalid`, next request handled normally.
